// File: rtl/pkt_decoder.sv
// UART command-packet decoder: header, LSB-first payload, XOR checksum; drives registered pattern/period/control fields.
// done_tick_o and the updated fields appear one cycle after the checksum strobe; err_tick_o flags drop/checksum/timeout.
module pkt_decoder #(
  parameter int DATA_BIT    = 32,
  parameter int CH_NUM      = 4,
  parameter int TIMEOUT_CYC = 100000,
  localparam int CHW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [7:0]          data_i,
  input  logic                rx_done_tick_i,
  output logic [DATA_BIT-1:0] output_pattern_o,
  output logic [DATA_BIT-1:0] freq_pattern_o,
  output logic [7:0]          slow_period_o,
  output logic [7:0]          fast_period_o,
  output logic                start_o,
  output logic                stop_o,
  output logic                mode_o,
  output logic [3:0]          sel_out_o,
  output logic [CHW-1:0]      ch_o,
  output logic [3:0]          cmd_o,
  output logic                done_tick_o,
  output logic                err_tick_o,
  output logic [1:0]          err_code_o
);

  localparam int NB   = DATA_BIT / 8;
  localparam int BUFW = 8 * (NB + 2);
  localparam int CW   = $clog2(NB + 3);
  localparam int IW   = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  localparam logic [CW-1:0] LEN_FREQ  = CW'(NB + 2);
  localparam logic [CW-1:0] LEN_DATA  = CW'(NB + 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_CYC - 1);
  localparam logic [3:0]    OP_FREQ   = 4'hA;
  localparam logic [3:0]    OP_DATA   = 4'hB;

  localparam logic [1:0] ERR_HDR  = 2'b01;
  localparam logic [1:0] ERR_CSUM = 2'b10;
  localparam logic [1:0] ERR_TO   = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Packet-in-flight context
  logic [CHW-1:0]      hch_q, hch_d;
  logic [3:0]          hop_q, hop_d;
  logic [BUFW-1:0]     buf_q, buf_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [7:0]          csum_q, csum_d;
  logic [IW-1:0]       idle_q, idle_d;

  // Registered output fields
  logic [DATA_BIT-1:0] pat_q, pat_d;
  logic [DATA_BIT-1:0] fpat_q, fpat_d;
  logic [7:0]          slow_q, slow_d;
  logic [7:0]          fast_q, fast_d;
  logic                start_q, start_d;
  logic                stop_q, stop_d;
  logic                mode_q, mode_d;
  logic [3:0]          sel_q, sel_d;
  logic [CHW-1:0]      ch_q, ch_d;
  logic [3:0]          cmd_q, cmd_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [1:0]          errc_q, errc_d;

  logic                hdr_ok;
  logic                timeout;
  logic [CW-1:0]       cnt_inc;
  logic [CW-1:0]       pay_len;

  assign hdr_ok  = ((data_i[3:0] == OP_FREQ) || (data_i[3:0] == OP_DATA)) &&
                   (int'(data_i[7:4]) < CH_NUM);
  assign timeout = (idle_q == IDLE_LAST);
  assign cnt_inc = cnt_q + CW'(1);
  assign pay_len = (hop_q == OP_FREQ) ? LEN_FREQ : LEN_DATA;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      hch_q   <= '0;
      hop_q   <= '0;
      buf_q   <= '0;
      cnt_q   <= '0;
      csum_q  <= '0;
      idle_q  <= '0;
      pat_q   <= '0;
      fpat_q  <= '0;
      slow_q  <= '0;
      fast_q  <= '0;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      mode_q  <= 1'b0;
      sel_q   <= '0;
      ch_q    <= '0;
      cmd_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      errc_q  <= '0;
    end else begin
      state_q <= state_d;
      hch_q   <= hch_d;
      hop_q   <= hop_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      csum_q  <= csum_d;
      idle_q  <= idle_d;
      pat_q   <= pat_d;
      fpat_q  <= fpat_d;
      slow_q  <= slow_d;
      fast_q  <= fast_d;
      start_q <= start_d;
      stop_q  <= stop_d;
      mode_q  <= mode_d;
      sel_q   <= sel_d;
      ch_q    <= ch_d;
      cmd_q   <= cmd_d;
      done_q  <= done_d;
      err_q   <= err_d;
      errc_q  <= errc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hch_d   = hch_q;
    hop_d   = hop_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    csum_d  = csum_q;
    idle_d  = '0;
    pat_d   = pat_q;
    fpat_d  = fpat_q;
    slow_d  = slow_q;
    fast_d  = fast_q;
    start_d = start_q;
    stop_d  = stop_q;
    mode_d  = mode_q;
    sel_d   = sel_q;
    ch_d    = ch_q;
    cmd_d   = cmd_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    errc_d  = errc_q;

    // Inter-byte watchdog only runs while a packet is open
    if ((state_q == PAYLOAD) || (state_q == CHECK)) begin
      idle_d = rx_done_tick_i ? '0 : idle_q + IW'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (rx_done_tick_i) begin
          if (hdr_ok) begin
            hch_d   = data_i[CHW-1+4:4];
            hop_d   = data_i[3:0];
            csum_d  = data_i;
            cnt_d   = '0;
            state_d = PAYLOAD;
          end else begin
            err_d  = 1'b1;
            errc_d = ERR_HDR;
          end
        end
      end

      PAYLOAD: begin
        if (rx_done_tick_i) begin
          // Shift right so the first (LSB) byte lands at bit 0 after a FREQ payload
          buf_d  = {data_i, buf_q[BUFW-1:8]};
          csum_d = csum_q ^ data_i;
          cnt_d  = cnt_inc;
          if (cnt_inc == pay_len) begin
            state_d = CHECK;
          end
        end else if (timeout) begin
          err_d   = 1'b1;
          errc_d  = ERR_TO;
          state_d = IDLE;
        end
      end

      CHECK: begin
        if (rx_done_tick_i) begin
          if (data_i == csum_q) begin
            done_d  = 1'b1;
            ch_d    = hch_q;
            cmd_d   = hop_q;
            state_d = DONE;
            if (hop_q == OP_FREQ) begin
              fpat_d = buf_q[DATA_BIT-1:0];
              slow_d = buf_q[DATA_BIT +: 8];
              fast_d = buf_q[DATA_BIT+8 +: 8];
            end else begin
              // DATA payload is one byte shorter, so it sits one byte higher in the buffer
              pat_d   = buf_q[8 +: DATA_BIT];
              start_d = buf_q[BUFW-8];
              stop_d  = buf_q[BUFW-7];
              mode_d  = buf_q[BUFW-6];
              sel_d   = buf_q[BUFW-4 +: 4];
            end
          end else begin
            err_d   = 1'b1;
            errc_d  = ERR_CSUM;
            state_d = IDLE;
          end
        end else if (timeout) begin
          err_d   = 1'b1;
          errc_d  = ERR_TO;
          state_d = IDLE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign output_pattern_o = pat_q;
  assign freq_pattern_o   = fpat_q;
  assign slow_period_o    = slow_q;
  assign fast_period_o    = fast_q;
  assign start_o          = start_q;
  assign stop_o           = stop_q;
  assign mode_o           = mode_q;
  assign sel_out_o        = sel_q;
  assign ch_o             = ch_q;
  assign cmd_o            = cmd_q;
  assign done_tick_o      = done_q;
  assign err_tick_o       = err_q;
  assign err_code_o       = errc_q;

endmodule

// File: tb/tb_pkt_decoder.sv
// Scoreboard bench for pkt_decoder: expected tick events with full output snapshots are queued as packets are sent.
module tb_pkt_decoder;

  localparam int DATA_BIT = 32;
  localparam int CH_NUM   = 4;
  localparam int TO       = 40;

  logic                clk_i = 1'b0;
  logic                rst_ni = 1'b0;
  logic [7:0]          data_i = 8'h00;
  logic                rx_done_tick_i = 1'b0;
  logic [DATA_BIT-1:0] output_pattern_o;
  logic [DATA_BIT-1:0] freq_pattern_o;
  logic [7:0]          slow_period_o;
  logic [7:0]          fast_period_o;
  logic                start_o;
  logic                stop_o;
  logic                mode_o;
  logic [3:0]          sel_out_o;
  logic [1:0]          ch_o;
  logic [3:0]          cmd_o;
  logic                done_tick_o;
  logic                err_tick_o;
  logic [1:0]          err_code_o;

  pkt_decoder #(
    .DATA_BIT    (DATA_BIT),
    .CH_NUM      (CH_NUM),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .data_i           (data_i),
    .rx_done_tick_i   (rx_done_tick_i),
    .output_pattern_o (output_pattern_o),
    .freq_pattern_o   (freq_pattern_o),
    .slow_period_o    (slow_period_o),
    .fast_period_o    (fast_period_o),
    .start_o          (start_o),
    .stop_o           (stop_o),
    .mode_o           (mode_o),
    .sel_out_o        (sel_out_o),
    .ch_o             (ch_o),
    .cmd_o            (cmd_o),
    .done_tick_o      (done_tick_o),
    .err_tick_o       (err_tick_o),
    .err_code_o       (err_code_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic        is_err;
    logic [1:0]  code;
    logic [31:0] pat;
    logic [31:0] fpat;
    logic [7:0]  slow;
    logic [7:0]  fast;
    logic        start;
    logic        stop;
    logic        mode;
    logic [3:0]  sel;
    logic [1:0]  ch;
    logic [3:0]  cmd;
  } ev_t;

  int         checks = 0;
  int         errors = 0;
  ev_t        sb[$];
  ev_t        mdl;
  ev_t        mon_e;
  logic [7:0] tx_q[$];
  logic       rx_at_edge = 1'b0;
  logic [92:0] act_f;
  logic [92:0] exp_f;

  always @(posedge clk_i) rx_at_edge <= rx_done_tick_i;

  // Monitor: every tick must match the head of the scoreboard, including the full field snapshot
  always @(negedge clk_i) begin
    if (done_tick_o && err_tick_o) begin
      checks++;
      errors++;
      $display("FAIL tick_overlap: done_tick_o=1 err_tick_o=1, required never both");
    end
    if (done_tick_o || err_tick_o) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_tick: done=%0b err=%0b code=%b, required no tick", done_tick_o, err_tick_o, err_code_o);
      end else begin
        mon_e = sb.pop_front();
        if ((done_tick_o !== !mon_e.is_err) || (mon_e.is_err && (err_code_o !== mon_e.code))) begin
          errors++;
          $display("FAIL tick_kind: done=%0b err=%0b code=%b, required err=%0b code=%b", done_tick_o, err_tick_o, err_code_o, mon_e.is_err, mon_e.code);
        end
        act_f = {output_pattern_o, freq_pattern_o, slow_period_o, fast_period_o, start_o, stop_o, mode_o, sel_out_o, ch_o, cmd_o};
        exp_f = {mon_e.pat, mon_e.fpat, mon_e.slow, mon_e.fast, mon_e.start, mon_e.stop, mon_e.mode, mon_e.sel, mon_e.ch, mon_e.cmd};
        checks++;
        if (act_f !== exp_f) begin
          errors++;
          $display("FAIL fields: got %h, required %h", act_f, exp_f);
        end
        if (done_tick_o) begin
          checks++;
          if (rx_at_edge !== 1'b1) begin
            errors++;
            $display("FAIL done_latency: strobe in previous cycle=%0b, required 1", rx_at_edge);
          end
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk_i);
    data_i = b;
    rx_done_tick_i = 1'b1;
    @(negedge clk_i);
    rx_done_tick_i = 1'b0;
    data_i = 8'h00;
    repeat (gap) @(negedge clk_i);
  endtask

  task automatic send_tx(input int gap);
    for (int i = 0; i < tx_q.size(); i++) send_byte(tx_q[i], gap);
    tx_q.delete();
  endtask

  task automatic expect_data_done();
    mdl.pat   = 32'h12345678;
    mdl.ch    = 2'd1;
    mdl.cmd   = 4'hB;
    mdl.start = 1'b1;
    mdl.stop  = 1'b0;
    mdl.mode  = 1'b1;
    mdl.sel   = 4'd3;
    mdl.is_err = 1'b0;
    mdl.code  = 2'b00;
    sb.push_back(mdl);
  endtask

  task automatic expect_err(input logic [1:0] code);
    ev_t e;
    e = mdl;
    e.is_err = 1'b1;
    e.code = code;
    sb.push_back(e);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk_i);
    repeat (4) @(negedge clk_i);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d expected ticks missing, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic send_good_data(input int gap);
    tx_q = '{8'h1B, 8'h78, 8'h56, 8'h34, 8'h12, 8'h35, 8'h26};
    expect_data_done();
    send_tx(gap);
  endtask

  task automatic test_reset();
    mdl = '0;
    repeat (3) @(negedge clk_i);
    checks++;
    if ({act_all()} !== '0) begin
      errors++;
      $display("FAIL reset_state: got %h, required 0", act_all());
    end
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);
  endtask

  function automatic logic [96:0] act_all();
    return {output_pattern_o, freq_pattern_o, slow_period_o, fast_period_o, start_o, stop_o,
            mode_o, sel_out_o, ch_o, cmd_o, done_tick_o, err_tick_o, err_code_o};
  endfunction

  task automatic test_data();
    send_good_data(2);
    wait_drain("data");
  endtask

  task automatic test_freq();
    tx_q = '{8'h0A, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h10, 8'h20, 8'h18};
    mdl.fpat = 32'hDEADBEEF;
    mdl.slow = 8'h10;
    mdl.fast = 8'h20;
    mdl.ch   = 2'd0;
    mdl.cmd  = 4'hA;
    mdl.is_err = 1'b0;
    sb.push_back(mdl);
    send_tx(1);
    wait_drain("freq");
  endtask

  task automatic test_bad_checksum();
    tx_q = '{8'h1B, 8'h78, 8'h56, 8'h34, 8'h12, 8'h35, 8'h27};
    expect_err(2'b10);
    send_tx(2);
    wait_drain("bad_csum");
    checks++;
    if (err_code_o !== 2'b10) begin
      errors++;
      $display("FAIL err_code_hold: got %b, required 10", err_code_o);
    end
  endtask

  task automatic test_bad_header();
    expect_err(2'b01);
    expect_err(2'b01);
    send_byte(8'h0C, 2);
    send_byte(8'h5B, 2);
    wait_drain("bad_hdr");
    checks++;
    if (err_code_o !== 2'b01) begin
      errors++;
      $display("FAIL err_code_hdr: got %b, required 01", err_code_o);
    end
    send_good_data(0);
    wait_drain("after_bad_hdr");
  endtask

  task automatic test_timeout();
    int k;
    expect_err(2'b11);
    send_byte(8'h1B, 2);
    send_byte(8'h78, 0);
    k = 0;
    for (int i = 1; i <= 3 * TO && k == 0; i++) begin
      @(negedge clk_i);
      if (err_tick_o) k = i;
    end
    checks++;
    if (k != TO) begin
      errors++;
      $display("FAIL timeout_latency: err tick after %0d cycles, required %0d", k, TO);
    end
    wait_drain("timeout");
    send_good_data(2);
    wait_drain("after_timeout");
  endtask

  task automatic test_byte_wins();
    // Each byte lands exactly on the cycle the watchdog would fire
    send_good_data(TO - 2);
    wait_drain("byte_wins");
  endtask

  task automatic test_reset_mid();
    tx_q = '{8'h1B, 8'h78, 8'h56, 8'h34};
    send_tx(2);
    @(negedge clk_i);
    rst_ni = 1'b0;
    mdl = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      checks++;
      if (act_all() !== '0) begin
        errors++;
        $display("FAIL reset_mid_state: got %h, required 0", act_all());
      end
    end
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);
    send_good_data(2);
    wait_drain("after_reset_mid");
  endtask

  initial begin
    test_reset();
    test_data();
    test_freq();
    test_bad_checksum();
    test_bad_header();
    test_timeout();
    test_byte_wins();
    test_reset_mid();
    repeat (5) @(negedge clk_i);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pkt_decoder.md
PKT_DECODER -- requirements
Module: pkt_decoder

Interface
REQ-001 SHALL have parameter DATA_BIT, default 32, meaning pattern width in bits; multiple of 8, 8..64.
REQ-002 SHALL have parameter CH_NUM, default 4, meaning number of addressable output channels; 1..16.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 100000, meaning the maximum idle clk_i cycles allowed between bytes of one packet.
REQ-004 SHALL have port clk_i, input, 1 bit, the system clock; all logic is rising-edge.
REQ-005 SHALL have port rst_ni, input, 1 bit, the reset; asynchronous, active-low.
REQ-006 SHALL have port data_i, input, 8 bits, the received UART byte; valid only while rx_done_tick_i=1.
REQ-007 SHALL have port rx_done_tick_i, input, 1 bit, a one-cycle byte strobe.
REQ-008 SHALL have ports output_pattern_o [DATA_BIT] and freq_pattern_o [DATA_BIT], outputs, the decoded patterns.
REQ-009 SHALL have ports slow_period_o [8] and fast_period_o [8], outputs, the decoded periods.
REQ-010 SHALL have ports start_o, stop_o and mode_o, outputs, 1 bit each, and sel_out_o, output, 4 bits, the decoded control fields.
REQ-011 SHALL have port ch_o, output, clog2(CH_NUM) bits (minimum 1), the channel of the last good packet.
REQ-012 SHALL have port cmd_o, output, 4 bits, the opcode of the last good packet.
REQ-013 SHALL have port done_tick_o, output, 1 bit, a one-cycle pulse per good packet.
REQ-014 SHALL have ports err_tick_o, output, 1 bit, a one-cycle error pulse, and err_code_o, output, 2 bits, the error cause.

Function
REQ-015 SHALL decode the packet as: header byte, then payload (LSB byte first), then checksum byte. Header[7:4] = channel; header[3:0] = opcode.
REQ-016 SHALL support opcode 0xA (FREQ) with payload length DATA_BIT/8+2: pattern, then slow period, then fast period.
REQ-017 SHALL support opcode 0xB (DATA) with payload length DATA_BIT/8+1: pattern, then control byte. Control byte: bit0 start, bit1 stop, bit2 mode, bits[7:4] sel.
REQ-018 SHALL implement states IDLE, PAYLOAD, CHECK and DONE; any illegal state SHALL go to IDLE.
REQ-019 In IDLE, a byte whose opcode is known and whose channel is < CH_NUM SHALL be latched and move the FSM to PAYLOAD, with byte count cleared and running XOR set to the header byte.
REQ-020 In IDLE, a byte with an unknown opcode or channel >= CH_NUM SHALL be dropped, pulse err_tick_o with err_code_o=01, and keep the FSM in IDLE.
REQ-021 In PAYLOAD, each byte SHALL shift into the buffer, XOR into the checksum and increment the count. The byte making count = payload length SHALL move the FSM to CHECK.
REQ-022 In CHECK, on a byte equal to the running XOR, the FSM SHALL go to DONE; otherwise it SHALL pulse err_tick_o with err_code_o=10 and go to IDLE.
REQ-023 In DONE (one cycle), the block SHALL register all fields of the opcode into the outputs, assert done_tick_o, and go to IDLE. Fields of the other opcode SHALL be unchanged.
REQ-024 Outputs other than the tick outputs SHALL be registered and SHALL hold their values until the next good packet.
REQ-025 done_tick_o SHALL rise in the cycle after the checksum strobe (latency 1), together with the updated outputs.
REQ-026 In PAYLOAD/CHECK, an idle counter SHALL clear on every rx_done_tick_i and increment otherwise.
REQ-027 When the idle counter reaches TIMEOUT_CYC-1, the block SHALL discard the packet, pulse err_tick_o with err_code_o=11, and go to IDLE.
REQ-028 If a byte strobe and the timeout occur in the same cycle, the byte SHALL win and no timeout SHALL be reported.
REQ-029 err_code_o SHALL hold the last error code; done_tick_o and err_tick_o SHALL never be asserted in the same cycle.
REQ-030 The payload buffer and counters SHALL be sized from the parameters, and the count SHALL never wrap within one packet.

Reset
REQ-031 While rst_ni=0, the block SHALL be in IDLE with all outputs, buffers, counters and err_code_o at 0.
REQ-032 A reset assertion mid-packet SHALL abort the packet with no tick output; after release, the next byte SHALL be treated as a header.

Verification
REQ-033 The bench SHALL send DATA: 1B 78 56 34 12 35 26. Required: done_tick_o pulse; output_pattern_o=0x12345678; ch_o=1; cmd_o=B; start_o=1; stop_o=0; mode_o=1; sel_out_o=3.
REQ-034 The bench SHALL send FREQ: 0A EF BE AD DE 10 20 18. Required: freq_pattern_o=0xDEADBEEF; slow_period_o=0x10; fast_period_o=0x20; ch_o=0; DATA fields unchanged.
REQ-035 The bench SHALL send the REQ-033 packet with checksum 27. Required: err_tick_o pulse with err_code_o=10; no done_tick_o; outputs unchanged.
REQ-036 The bench SHALL send headers 0C and then 5B (CH_NUM=4). Required: two err_tick_o pulses with code 01; FSM stays in IDLE.
REQ-037 The bench SHALL send 1B 78 and then stay silent for TIMEOUT_CYC cycles, then send the full REQ-033 packet. Required: err code 11, then a good decode.
REQ-038 The bench SHALL assert rst_ni low after 3 payload bytes. Required: all outputs 0, no tick outputs, and the next full packet decodes correctly.
